// File: rtl/clock_analyzer_if.sv
// Bus bundle for clock_analyzer.
//   sig_in     : asynchronous waveform under measurement (master -> slave)
//   start      : one-cycle measurement start / phase reference (master -> slave)
//   phase_cnt  : cycles from start to the first rising edge
//   high_cnt   : high cycles of the last complete period
//   low_cnt    : low cycles of the last complete period
//   period_cnt : high_cnt + low_cnt, saturated
//   duty_pct   : floor(high_cnt * 100 / period_cnt)
//   meas_valid : one-cycle pulse when the result outputs update
//   stuck_hi/stuck_lo/overrun : sticky status flags
interface clock_analyzer_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             sig_in;
  logic             start;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [6:0]       duty_pct;
  logic             meas_valid;
  logic             stuck_hi;
  logic             stuck_lo;
  logic             overrun;

  modport master (
    output sig_in, start,
    input  phase_cnt, high_cnt, low_cnt, period_cnt, duty_pct,
    input  meas_valid, stuck_hi, stuck_lo, overrun
  );

  modport slave (
    input  sig_in, start,
    output phase_cnt, high_cnt, low_cnt, period_cnt, duty_pct,
    output meas_valid, stuck_hi, stuck_lo, overrun
  );
endinterface

// File: rtl/clock_analyzer.sv
// Measures phase (start to first rising edge), high/low time, period and duty cycle of an
// asynchronous waveform, in reference-clock cycles.
//   clk : reference clock, rising edge
//   rst : synchronous active-high reset
//   bus : clock_analyzer_if slave (sig_in/start in, results and flags out)
module clock_analyzer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1000
) (
  input logic             clk,
  input logic             rst,
  clock_analyzer_if.slave bus
);
  localparam int unsigned DivW   = CNT_W + 7;
  localparam int unsigned DivCyc = CNT_W + 7;
  localparam int unsigned DcW    = $clog2(DivCyc + 1);
  localparam int unsigned ToW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StWaitPhase, StMeasHigh, StMeasLow} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sig_dly_q, sig_dly_d;
  logic [CNT_W-1:0]       phase_ctr_q, phase_ctr_d;
  logic [CNT_W-1:0]       run_ctr_q, run_ctr_d;
  logic [CNT_W-1:0]       high_hold_q, high_hold_d;
  logic [ToW-1:0]         idle_ctr_q, idle_ctr_d;
  logic                   div_busy_q, div_busy_d;
  logic [DcW-1:0]         div_cnt_q, div_cnt_d;
  logic [DivW-1:0]        div_num_q, div_num_d;
  logic [CNT_W:0]         div_rem_q, div_rem_d;
  logic [CNT_W:0]         div_den_q, div_den_d;
  logic [CNT_W-1:0]       div_high_q, div_high_d;
  logic [CNT_W-1:0]       div_low_q, div_low_d;
  logic [CNT_W-1:0]       phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]       low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0]       period_cnt_q, period_cnt_d;
  logic [6:0]             duty_q, duty_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   stuck_hi_q, stuck_hi_d;
  logic                   stuck_lo_q, stuck_lo_d;
  logic                   overrun_q, overrun_d;

  logic             sig_s, rise, fall, abort;
  logic [CNT_W+1:0] rem_shift;
  logic [CNT_W:0]   rem_diff;
  logic             q_bit;
  logic [DivW-1:0]  num_next;
  logic [CNT_W-1:0] run_inc, phase_inc;
  logic [CNT_W:0]   per_sum;

  assign sig_s     = sync_q[SYNC_STAGES-1];
  assign rise      = sig_s & ~sig_dly_q;
  assign fall      = ~sig_s & sig_dly_q;
  assign abort     = bus.start && (state_q != StIdle);
  assign run_inc   = sat_inc(run_ctr_q);
  assign phase_inc = sat_inc(phase_ctr_q);
  assign per_sum   = {1'b0, high_hold_q} + {1'b0, run_inc};

  // Restoring divide step. The remainder stays below the divisor, so a set MSB after the
  // shift already guarantees a subtract and the difference fits in CNT_W+1 bits.
  assign rem_shift = {div_rem_q, div_num_q[DivW-1]};
  assign q_bit     = rem_shift[CNT_W+1] | (rem_shift[CNT_W:0] >= div_den_q);
  assign rem_diff  = rem_shift[CNT_W:0] - div_den_q;
  assign num_next  = {div_num_q[DivW-2:0], q_bit};

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[SYNC_STAGES-2:0], bus.sig_in};
    sig_dly_d    = sig_s;
    phase_ctr_d  = phase_ctr_q;
    run_ctr_d    = run_ctr_q;
    high_hold_d  = high_hold_q;
    idle_ctr_d   = idle_ctr_q;
    div_busy_d   = div_busy_q;
    div_cnt_d    = div_cnt_q;
    div_num_d    = div_num_q;
    div_rem_d    = div_rem_q;
    div_den_d    = div_den_q;
    div_high_d   = div_high_q;
    div_low_d    = div_low_q;
    phase_cnt_d  = phase_cnt_q;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    period_cnt_d = period_cnt_q;
    duty_d       = duty_q;
    meas_valid_d = 1'b0;
    stuck_hi_d   = stuck_hi_q;
    stuck_lo_d   = stuck_lo_q;
    overrun_d    = overrun_q;

    // Divider; the quotient accumulates in the low bits of div_num as the dividend shifts out.
    if (div_busy_q) begin
      div_rem_d = q_bit ? rem_diff : rem_shift[CNT_W:0];
      div_num_d = num_next;
      div_cnt_d = div_cnt_q - 1'b1;
      if (div_cnt_q == DcW'(1)) begin
        div_busy_d = 1'b0;
        if (!abort) begin
          meas_valid_d = 1'b1;
          high_cnt_d   = div_high_q;
          low_cnt_d    = div_low_q;
          period_cnt_d = div_den_q[CNT_W] ? '1 : div_den_q[CNT_W-1:0];
          duty_d       = num_next[6:0];
        end
      end
    end

    if (bus.start) begin
      // Start wins over any edge in the same cycle.
      state_d     = StWaitPhase;
      phase_ctr_d = '0;
      idle_ctr_d  = '0;
      if (abort) begin
        div_busy_d = 1'b0;
        overrun_d  = 1'b0;
        stuck_hi_d = 1'b0;
        stuck_lo_d = 1'b0;
      end
    end else if (state_q != StIdle) begin
      unique case (state_q)
        StWaitPhase: begin
          phase_ctr_d = phase_inc;
          if (rise) begin
            phase_cnt_d = phase_inc;
            run_ctr_d   = '0;
            state_d     = StMeasHigh;
          end
        end
        StMeasHigh: begin
          run_ctr_d = run_inc;
          if (fall) begin
            high_hold_d = run_inc;
            run_ctr_d   = '0;
            state_d     = StMeasLow;
          end
        end
        StMeasLow: begin
          run_ctr_d = run_inc;
          if (rise) begin
            if (div_busy_q) begin
              overrun_d = 1'b1;
            end else begin
              div_busy_d = 1'b1;
              div_cnt_d  = DcW'(DivCyc);
              div_rem_d  = '0;
              div_num_d  = DivW'(high_hold_q) * DivW'(100);
              div_den_d  = per_sum;
              div_high_d = high_hold_q;
              div_low_d  = run_inc;
            end
            run_ctr_d = '0;
            state_d   = StMeasHigh;
          end
        end
        default: ;
      endcase

      if (rise || fall) begin
        idle_ctr_d = '0;
      end else if (idle_ctr_q == ToW'(TIMEOUT - 1)) begin
        idle_ctr_d = '0;
        state_d    = StIdle;
        if (sig_s) stuck_hi_d = 1'b1;
        else       stuck_lo_d = 1'b1;
      end else begin
        idle_ctr_d = idle_ctr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sync_q       <= '0;
      sig_dly_q    <= 1'b0;
      phase_ctr_q  <= '0;
      run_ctr_q    <= '0;
      high_hold_q  <= '0;
      idle_ctr_q   <= '0;
      div_busy_q   <= 1'b0;
      div_cnt_q    <= '0;
      div_num_q    <= '0;
      div_rem_q    <= '0;
      div_den_q    <= '0;
      div_high_q   <= '0;
      div_low_q    <= '0;
      phase_cnt_q  <= '0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      period_cnt_q <= '0;
      duty_q       <= '0;
      meas_valid_q <= 1'b0;
      stuck_hi_q   <= 1'b0;
      stuck_lo_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      sig_dly_q    <= sig_dly_d;
      phase_ctr_q  <= phase_ctr_d;
      run_ctr_q    <= run_ctr_d;
      high_hold_q  <= high_hold_d;
      idle_ctr_q   <= idle_ctr_d;
      div_busy_q   <= div_busy_d;
      div_cnt_q    <= div_cnt_d;
      div_num_q    <= div_num_d;
      div_rem_q    <= div_rem_d;
      div_den_q    <= div_den_d;
      div_high_q   <= div_high_d;
      div_low_q    <= div_low_d;
      phase_cnt_q  <= phase_cnt_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      period_cnt_q <= period_cnt_d;
      duty_q       <= duty_d;
      meas_valid_q <= meas_valid_d;
      stuck_hi_q   <= stuck_hi_d;
      stuck_lo_q   <= stuck_lo_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.phase_cnt  = phase_cnt_q;
  assign bus.high_cnt   = high_cnt_q;
  assign bus.low_cnt    = low_cnt_q;
  assign bus.period_cnt = period_cnt_q;
  assign bus.duty_pct   = duty_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.stuck_hi   = stuck_hi_q;
  assign bus.stuck_lo   = stuck_lo_q;
  assign bus.overrun    = overrun_q;
endmodule
